// File: rtl/oldland_mem_arbiter_pkg.sv
// Shared definitions for the oldland memory arbiter.
//   arb_state_t   : arbiter FSM states (IDLE / BUSY / DONE)
//   arb_grant_t   : which requester currently owns the bus (NONE / FETCH / DATA)
//   FETCH_BYTESEL : byte enables driven for every instruction fetch
package oldland_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DATA  = 2'd2
    } arb_grant_t;

    localparam logic [3:0] FETCH_BYTESEL = 4'b1111;

endpackage

// File: rtl/oldland_arb_timeout.sv
// Bus transaction watchdog for the oldland memory arbiter.
// Built only when OLDLAND_BUS_TIMEOUT_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (asserted on every grant)
//   run        : arbiter is waiting in BUSY
//   expired    : high during the TIMEOUT_CYCLES-th consecutive BUSY cycle
`ifdef OLDLAND_BUS_TIMEOUT_EN
module oldland_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The count is 0 in the first BUSY cycle, so expiry is one below the limit.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = run && (count == LAST);

endmodule
`endif

// File: rtl/oldland_mem_arbiter.sv
// oldland_mem_arbiter: shares one 32-bit memory bus between the instruction
// fetch port (i_*) and the load/store port (d_*). One transaction in flight;
// data has priority, but after DATA_BURST_MAX data grants with fetch waiting
// the next grant goes to fetch.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_access/i_addr                fetch request (held until i_ack)
//   i_data/i_ack/i_error           fetch response, qualified by i_ack
//   d_access/d_addr/d_wr_en/
//   d_wr_val/d_bytesel             data request (held until d_ack)
//   d_data/d_ack/d_error           data response, qualified by d_ack
//   m_access/m_addr/m_wr_en/
//   m_wr_val/m_bytesel             bus request, held stable until m_ack
//   m_data/m_ack                   bus response
// Optional: define OLDLAND_BUS_TIMEOUT_EN to abort a BUSY cycle after
// TIMEOUT_CYCLES without m_ack (ack with error=1, data=0). Without it BUSY
// waits forever and i_error/d_error stay 0.
module oldland_mem_arbiter
    import oldland_mem_arbiter_pkg::*;
#(
    parameter int DATA_BURST_MAX = 4
`ifdef OLDLAND_BUS_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_access,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_error,
    input  logic        d_access,
    input  logic [31:0] d_addr,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_val,
    input  logic [3:0]  d_bytesel,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,
    output logic        m_access,
    output logic [31:0] m_addr,
    output logic        m_wr_en,
    output logic [31:0] m_wr_val,
    output logic [3:0]  m_bytesel,
    input  logic [31:0] m_data,
    input  logic        m_ack
);

    localparam int CTR_W = $clog2(DATA_BURST_MAX + 1);
    localparam logic [CTR_W-1:0] BURST_LIM = CTR_W'(DATA_BURST_MAX);

    arb_state_t       state, state_next;
    arb_grant_t       grant;
    logic [CTR_W-1:0] burst_ctr;
    logic             take_data, take_fetch;
    logic             finish_ok, finish_abort, finish;
    logic             timeout_hit;
    logic [31:0]      resp_data;

`ifdef OLDLAND_BUS_TIMEOUT_EN
    oldland_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (take_data | take_fetch),
        .run    (state == ST_BUSY),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        take_data    = 1'b0;
        take_fetch   = 1'b0;
        finish_ok    = 1'b0;
        finish_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                // Data wins unless it has used up its burst while fetch waits.
                if (d_access && (!i_access || (burst_ctr < BURST_LIM))) begin
                    take_data  = 1'b1;
                    state_next = ST_BUSY;
                end else if (i_access) begin
                    take_fetch = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real ack in the expiry cycle completes normally.
                if (m_ack) begin
                    finish_ok  = 1'b1;
                    state_next = ST_DONE;
                end else if (timeout_hit) begin
                    finish_abort = 1'b1;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                // Requester is dropping its access this cycle; ignore it.
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign finish    = finish_ok | finish_abort;
    assign resp_data = finish_abort ? 32'h0 : m_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= GNT_NONE;
            burst_ctr <= '0;
            m_access  <= 1'b0;
            m_addr    <= '0;
            m_wr_en   <= 1'b0;
            m_wr_val  <= '0;
            m_bytesel <= '0;
            i_data    <= '0;
            i_ack     <= 1'b0;
            i_error   <= 1'b0;
            d_data    <= '0;
            d_ack     <= 1'b0;
            d_error   <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;

            if (take_data) begin
                grant     <= GNT_DATA;
                m_access  <= 1'b1;
                m_addr    <= d_addr;
                m_wr_en   <= d_wr_en;
                m_wr_val  <= d_wr_val;
                m_bytesel <= d_bytesel;
                // Only grants that bypass a waiting fetch count toward the burst.
                if (!i_access) begin
                    burst_ctr <= '0;
                end else if (burst_ctr != BURST_LIM) begin
                    burst_ctr <= burst_ctr + 1'b1;
                end
            end else if (take_fetch) begin
                grant     <= GNT_FETCH;
                m_access  <= 1'b1;
                m_addr    <= i_addr;
                m_wr_en   <= 1'b0;
                m_wr_val  <= '0;
                m_bytesel <= FETCH_BYTESEL;
                burst_ctr <= '0;
            end

            if (finish) begin
                m_access <= 1'b0;
                grant    <= GNT_NONE;
                case (grant)
                    GNT_FETCH: begin
                        i_ack   <= 1'b1;
                        i_data  <= resp_data;
                        i_error <= finish_abort;
                    end
                    GNT_DATA: begin
                        d_ack   <= 1'b1;
                        d_data  <= resp_data;
                        d_error <= finish_abort;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
// Self-checking bench for oldland_mem_arbiter. Expected bus transactions are
// queued as requests are driven and popped when the arbiter issues them.
module tb_oldland_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_access;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_ack;
    logic        i_error;
    logic        d_access;
    logic [31:0] d_addr;
    logic        d_wr_en;
    logic [31:0] d_wr_val;
    logic [3:0]  d_bytesel;
    logic [31:0] d_data;
    logic        d_ack;
    logic        d_error;
    logic        m_access;
    logic [31:0] m_addr;
    logic        m_wr_en;
    logic [31:0] m_wr_val;
    logic [3:0]  m_bytesel;
    logic [31:0] m_data;
    logic        m_ack;

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic        wr_en;
        logic [31:0] wr_val;
        logic [3:0]  bytesel;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    oldland_mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_access (i_access),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .i_ack    (i_ack),
        .i_error  (i_error),
        .d_access (d_access),
        .d_addr   (d_addr),
        .d_wr_en  (d_wr_en),
        .d_wr_val (d_wr_val),
        .d_bytesel(d_bytesel),
        .d_data   (d_data),
        .d_ack    (d_ack),
        .d_error  (d_error),
        .m_access (m_access),
        .m_addr   (m_addr),
        .m_wr_en  (m_wr_en),
        .m_wr_val (m_wr_val),
        .m_bytesel(m_bytesel),
        .m_data   (m_data),
        .m_ack    (m_ack)
    );

    // Waits (bounded) for m_access; cycles = negedges waited.
    task automatic wait_grant(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!m_access && cycles < 20);
    endtask

    // Bus slave: after 'delay' cycles pulse m_ack for one cycle with rdata.
    // Returns at the negedge where the requester ack is visible.
    task automatic bus_respond(input int delay, input logic [31:0] rdata);
        repeat (delay) @(negedge clk);
        m_ack  = 1'b1;
        m_data = rdata;
        @(negedge clk);
        m_ack  = 1'b0;
        m_data = $urandom;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({m_access, m_addr, m_wr_en, m_wr_val, m_bytesel, i_data, i_ack, i_error,
             d_data, d_ack, d_error} !== '0)
            $display("FAIL reset_outputs: got m_access=%b m_addr=%h i_ack=%b d_ack=%b required all zero",
                     m_access, m_addr, i_ack, d_ack);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_access, i_ack, d_ack} !== 3'b000)
            $display("FAIL idle_no_request: got %b required 000", {m_access, i_ack, d_ack});
        else n_pass++;
    endtask

    task automatic test_fetch_read();
        txn_t e;
        int   cyc;
        exp_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0, 4'hf, 32'hdeadbeef});
        i_addr   = 32'h100;
        i_access = 1'b1;
        wait_grant(cyc);
        n_checks++;
        if (m_access !== 1'b1 || cyc != 1)
            $display("FAIL fetch_grant_latency: got m_access=%b cycles=%0d required 1 after 1", m_access, cyc);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if ({m_addr, m_wr_en, m_wr_val, m_bytesel} !== {e.addr, e.wr_en, e.wr_val, e.bytesel})
            $display("FAIL fetch_bus_fields: got addr=%h we=%b wv=%h bs=%h required addr=%h we=%b wv=%h bs=%h",
                     m_addr, m_wr_en, m_wr_val, m_bytesel, e.addr, e.wr_en, e.wr_val, e.bytesel);
        else n_pass++;
        bus_respond(2, e.rdata);
        n_checks++;
        if ({i_ack, i_error, d_ack} !== 3'b100 || i_data !== e.rdata)
            $display("FAIL fetch_ack: got ack/err/d_ack=%b data=%h required 100 data=%h",
                     {i_ack, i_error, d_ack}, i_data, e.rdata);
        else n_pass++;
        i_access = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({i_ack, m_access} !== 2'b00 || i_data !== e.rdata)
            $display("FAIL fetch_ack_pulse: got i_ack/m_access=%b data=%h required 00 data=%h",
                     {i_ack, m_access}, i_data, e.rdata);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        txn_t        e;
        int          cyc;
        logic [31:0] got;
        exp_q.push_back('{1'b1, 32'h300, 1'b0, 32'h0, 4'hf, 32'h3333_0000});
        exp_q.push_back('{1'b0, 32'h200, 1'b0, 32'h0, 4'hf, 32'h2222_0000});
        d_addr = 32'h300; d_wr_en = 1'b0; d_wr_val = 32'h0; d_bytesel = 4'hf;
        i_addr = 32'h200;
        d_access = 1'b1;
        i_access = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_grant(cyc);
            e = exp_q.pop_front();
            n_checks++;
            if (m_access !== 1'b1 || m_addr !== e.addr)
                $display("FAIL simul_order_%0d: got m_access=%b m_addr=%h required 1 %h", k, m_access, m_addr, e.addr);
            else n_pass++;
            bus_respond(1, e.rdata);
            got = e.is_data ? d_data : i_data;
            n_checks++;
            if ({i_ack, d_ack} !== (e.is_data ? 2'b01 : 2'b10) || got !== e.rdata)
                $display("FAIL simul_ack_%0d: got i_ack/d_ack=%b data=%h required %b data=%h",
                         k, {i_ack, d_ack}, got, (e.is_data ? 2'b01 : 2'b10), e.rdata);
            else n_pass++;
            if (e.is_data) d_access = 1'b0;
            else           i_access = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({i_ack, d_ack} !== 2'b00)
                $display("FAIL simul_pulse_%0d: got %b required 00", k, {i_ack, d_ack});
            else n_pass++;
        end
    endtask

    task automatic test_data_write();
        txn_t e;
        int   cyc;
        exp_q.push_back('{1'b1, 32'h400, 1'b1, 32'h1234_5678, 4'b0011, 32'ha5a5_a5a5});
        d_addr = 32'h400; d_wr_en = 1'b1; d_wr_val = 32'h1234_5678; d_bytesel = 4'b0011;
        d_access = 1'b1;
        wait_grant(cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (m_access !== 1'b1 || {m_addr, m_wr_en, m_wr_val, m_bytesel} !== {e.addr, e.wr_en, e.wr_val, e.bytesel})
            $display("FAIL write_bus_fields: got addr=%h we=%b wv=%h bs=%h required addr=%h we=%b wv=%h bs=%h",
                     m_addr, m_wr_en, m_wr_val, m_bytesel, e.addr, e.wr_en, e.wr_val, e.bytesel);
        else n_pass++;
        bus_respond(3, e.rdata);
        n_checks++;
        if ({d_ack, d_error, i_ack} !== 3'b100 || d_data !== e.rdata)
            $display("FAIL write_ack: got ack/err/i_ack=%b data=%h required 100 data=%h",
                     {d_ack, d_error, i_ack}, d_data, e.rdata);
        else n_pass++;
        n_checks++;
        if (i_data !== 32'h2222_0000)
            $display("FAIL write_i_data_hold: got %h required 22220000", i_data);
        else n_pass++;
        d_access = 1'b0;
        d_wr_en  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_ack !== 1'b0)
            $display("FAIL write_ack_pulse: got %b required 0", d_ack);
        else n_pass++;
    endtask

    task automatic test_starvation();
        txn_t        e;
        int          cyc;
        logic [31:0] got;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) exp_q.push_back('{1'b0, 32'h600, 1'b0, 32'h0, 4'hf, 32'h5000_0000 + k});
            else            exp_q.push_back('{1'b1, 32'h500, 1'b0, 32'h0, 4'hf, 32'h5000_0000 + k});
        end
        d_addr = 32'h500; d_wr_en = 1'b0; d_wr_val = 32'h0; d_bytesel = 4'hf;
        i_addr = 32'h600;
        d_access = 1'b1;
        i_access = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_grant(cyc);
            e = exp_q.pop_front();
            n_checks++;
            if (m_access !== 1'b1 || m_addr !== e.addr)
                $display("FAIL starve_grant_%0d: got m_access=%b m_addr=%h required 1 %h", k, m_access, m_addr, e.addr);
            else n_pass++;
            bus_respond(0, e.rdata);
            got = e.is_data ? d_data : i_data;
            n_checks++;
            if ({i_ack, d_ack} !== (e.is_data ? 2'b01 : 2'b10) || got !== e.rdata)
                $display("FAIL starve_ack_%0d: got i_ack/d_ack=%b data=%h required %b data=%h",
                         k, {i_ack, d_ack}, got, (e.is_data ? 2'b01 : 2'b10), e.rdata);
            else n_pass++;
        end
        d_access = 1'b0;
        i_access = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_busy();
        txn_t e;
        int   cyc;
        int   bad_ack;
        exp_q.push_back('{1'b1, 32'h700, 1'b0, 32'h0, 4'hf, 32'h0});
        d_addr = 32'h700; d_wr_en = 1'b0; d_bytesel = 4'hf;
        d_access = 1'b1;
        wait_grant(cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (m_access !== 1'b1 || m_addr !== e.addr)
            $display("FAIL rstbusy_grant: got m_access=%b m_addr=%h required 1 %h", m_access, m_addr, e.addr);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_access !== 1'b0)
            $display("FAIL rstbusy_async_drop: got m_access=%b required 0", m_access);
        else n_pass++;
        d_access = 1'b0;
        bad_ack = 0;
        repeat (2) begin
            @(negedge clk);
            if (d_ack || i_ack) bad_ack++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (d_ack || i_ack || m_access) bad_ack++;
        end
        n_checks++;
        if (bad_ack != 0)
            $display("FAIL rstbusy_no_ack: got %0d stray cycles required 0", bad_ack);
        else n_pass++;
        exp_q.push_back('{1'b0, 32'h800, 1'b0, 32'h0, 4'hf, 32'h8888_8888});
        i_addr   = 32'h800;
        i_access = 1'b1;
        wait_grant(cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (m_access !== 1'b1 || {m_addr, m_bytesel} !== {e.addr, e.bytesel})
            $display("FAIL rstbusy_fresh_grant: got m_access=%b m_addr=%h bs=%h required 1 %h %h",
                     m_access, m_addr, m_bytesel, e.addr, e.bytesel);
        else n_pass++;
        bus_respond(1, e.rdata);
        n_checks++;
        if ({i_ack, d_ack} !== 2'b10 || i_data !== e.rdata)
            $display("FAIL rstbusy_fresh_ack: got i_ack/d_ack=%b data=%h required 10 data=%h",
                     {i_ack, d_ack}, i_data, e.rdata);
        else n_pass++;
        i_access = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef OLDLAND_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        int cnt;
        d_addr = 32'ha00; d_wr_en = 1'b0; d_bytesel = 4'hf;
        d_access = 1'b1;
        wait_grant(cyc);
        n_checks++;
        if (m_access !== 1'b1)
            $display("FAIL timeout_grant: got m_access=%b required 1", m_access);
        else n_pass++;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!d_ack && cnt < 400);
        n_checks++;
        if (cnt != 255)
            $display("FAIL timeout_latency: got %0d required 255", cnt);
        else n_pass++;
        n_checks++;
        if ({d_ack, d_error, m_access, i_ack} !== 4'b1100 || d_data !== 32'h0)
            $display("FAIL timeout_abort: got ack/err/m_access/i_ack=%b data=%h required 1100 data=00000000",
                     {d_ack, d_error, m_access, i_ack}, d_data);
        else n_pass++;
        d_access = 1'b0;
        repeat (2) @(negedge clk);
        // m_ack in the expiry cycle must complete normally.
        d_access = 1'b1;
        wait_grant(cyc);
        bus_respond(254, 32'hbeef_0001);
        n_checks++;
        if ({d_ack, d_error} !== 2'b10 || d_data !== 32'hbeef_0001)
            $display("FAIL timeout_ack_wins: got ack/err=%b data=%h required 10 data=beef0001",
                     {d_ack, d_error}, d_data);
        else n_pass++;
        d_access = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`else
    task automatic test_no_timeout();
        int cyc;
        int stray;
        d_addr = 32'h900; d_wr_en = 1'b0; d_bytesel = 4'hf;
        d_access = 1'b1;
        wait_grant(cyc);
        stray = 0;
        repeat (300) begin
            @(negedge clk);
            if (d_ack || i_ack || !m_access) stray++;
        end
        n_checks++;
        if (stray != 0)
            $display("FAIL busy_waits: got %0d bad cycles required 0", stray);
        else n_pass++;
        bus_respond(0, 32'h0000_0099);
        n_checks++;
        if ({d_ack, d_error} !== 2'b10 || d_data !== 32'h0000_0099)
            $display("FAIL busy_late_ack: got ack/err=%b data=%h required 10 data=00000099",
                     {d_ack, d_error}, d_data);
        else n_pass++;
        d_access = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        i_access  = 1'b0;
        i_addr    = '0;
        d_access  = 1'b0;
        d_addr    = '0;
        d_wr_en   = 1'b0;
        d_wr_val  = '0;
        d_bytesel = '0;
        m_data    = '0;
        m_ack     = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_fetch_read();
        test_simultaneous();
        test_data_write();
        test_starvation();
        test_reset_busy();
`ifdef OLDLAND_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
